// File: rtl/frontend_command_definition_pkg.sv
// Shared types and counter widths for the DRAM front-end read/write scheduler.
package frontend_command_definition_pkg;

    localparam int TURN_CNT_W   = 4;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_TURN  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rw_request_scheduler_if.sv
// FIFO-side and command-side signal bundle of the read/write scheduler.
interface rw_request_scheduler_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  rd_empty;
    logic                  wr_empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_flush;
    logic                  rd_pop;
    logic                  wr_pop;
    logic                  cmd_valid;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  cmd_ready;
    logic [1:0]            state;

    // master is the scheduler, slave is the FIFO/DRAM environment around it
    modport master (
        input  rd_empty, wr_empty, rd_data, wr_data, wr_flush, cmd_ready,
        output rd_pop, wr_pop, cmd_valid, cmd_write, cmd_data, state
    );
    modport slave (
        output rd_empty, wr_empty, rd_data, wr_data, wr_flush, cmd_ready,
        input  rd_pop, wr_pop, cmd_valid, cmd_write, cmd_data, state
    );
endinterface

// File: rtl/rw_request_scheduler.sv
// Read/write command scheduler with bus turnaround; optional write-starvation
// guard enabled by defining SCHED_STARVATION_GUARD_EN.
module rw_request_scheduler
    import frontend_command_definition_pkg::*;
#(
    parameter int DATA_WIDTH        = 1,
    parameter int TURNAROUND_CYCLES = 2,
    parameter int STARVE_LIMIT      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rd_empty,
    input  logic                  i_wr_empty,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_flush,
    output logic                  o_rd_pop,
    output logic                  o_wr_pop,
    output logic                  o_cmd_valid,
    output logic                  o_cmd_write,
    output logic [DATA_WIDTH-1:0] o_cmd_data,
    input  logic                  i_cmd_ready,
    output logic [1:0]            o_state
);

    // Out-of-range configurations fall back to a one-cycle turnaround.
    localparam bit CFG_OK = (TURNAROUND_CYCLES >= 1) && (TURNAROUND_CYCLES <= 15) &&
                            (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 255);
    localparam logic [TURN_CNT_W-1:0] TURN_LOAD =
        CFG_OK ? TURN_CNT_W'(TURNAROUND_CYCLES) : TURN_CNT_W'(1);

    sched_state_t          state_q, state_d;
    logic [TURN_CNT_W-1:0] turn_cnt_q, turn_cnt_d;
    logic                  turn_to_wr_q, turn_to_wr_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;

    logic starve_hit, slot_free, both_empty, go_write, go_read, rd_issue, wr_issue;

    assign both_empty = i_rd_empty && i_wr_empty;
    assign slot_free  = !cmd_valid_q || i_cmd_ready;
    assign go_write   = i_wr_flush || (i_rd_empty && !i_wr_empty) || starve_hit;
    assign go_read    = !i_rd_empty && (!i_wr_flush || i_wr_empty) && !starve_hit;

    // A pending exit wins over an issue, so a state change never shares a cycle with one.
    assign rd_issue = !i_rst && (state_q == ST_READ)  && !go_write && !i_rd_empty && slot_free;
    assign wr_issue = !i_rst && (state_q == ST_WRITE) && !go_read  && !i_wr_empty && slot_free;

`ifdef SCHED_STARVATION_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // While tripped, it also holds WRITE until one write has drained.
    assign starve_hit = (starve_cnt_q >= STARVE_CNT_W'(STARVE_LIMIT)) && !i_wr_empty;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (i_wr_empty || wr_issue)
            starve_cnt_d = '0;
        else if (rd_issue && (starve_cnt_q != '1))
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            turn_cnt_q   <= '0;
            turn_to_wr_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            turn_cnt_q   <= turn_cnt_d;
            turn_to_wr_q <= turn_to_wr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_write_q  <= cmd_write_d;
            cmd_data_q   <= cmd_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        turn_cnt_d   = turn_cnt_q;
        turn_to_wr_d = turn_to_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wr_flush || (i_rd_empty && !i_wr_empty)) state_d = ST_WRITE;
                else if (!i_rd_empty)                          state_d = ST_READ;
            end
            ST_READ: begin
                if (go_write) begin
                    state_d      = ST_TURN;
                    turn_cnt_d   = TURN_LOAD;
                    turn_to_wr_d = 1'b1;
                end else if (both_empty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (go_read) begin
                    state_d      = ST_TURN;
                    turn_cnt_d   = TURN_LOAD;
                    turn_to_wr_d = 1'b0;
                end else if (both_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (turn_cnt_q <= TURN_CNT_W'(1)) begin
                    state_d    = turn_to_wr_q ? ST_WRITE : ST_READ;
                    turn_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        o_rd_pop    = rd_issue;
        o_wr_pop    = wr_issue;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_data_d  = cmd_data_q;
        if (rd_issue || wr_issue) begin
            cmd_valid_d = 1'b1;
            cmd_write_d = wr_issue;
            cmd_data_d  = wr_issue ? i_wr_data : i_rd_data;
        end else if (cmd_valid_q && i_cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd_write = cmd_write_q;
    assign o_cmd_data  = cmd_data_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_rw_request_scheduler.sv
// Directed and random checks of rw_request_scheduler against a queue-based reference.
module tb_rw_request_scheduler;

    localparam int DW = 8;
    localparam int TC = 2;
    localparam int SL = 4;
    localparam int M_IDLE = 0, M_READ = 1, M_WRITE = 2, M_TURN = 3;
`ifdef SCHED_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rw_request_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    rw_request_scheduler #(
        .DATA_WIDTH(DW), .TURNAROUND_CYCLES(TC), .STARVE_LIMIT(SL)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rd_empty(bus.rd_empty), .i_wr_empty(bus.wr_empty),
        .i_rd_data(bus.rd_data), .i_wr_data(bus.wr_data),
        .i_wr_flush(bus.wr_flush),
        .o_rd_pop(bus.rd_pop), .o_wr_pop(bus.wr_pop),
        .o_cmd_valid(bus.cmd_valid), .o_cmd_write(bus.cmd_write),
        .o_cmd_data(bus.cmd_data), .i_cmd_ready(bus.cmd_ready),
        .o_state(bus.state)
    );

    logic [DW-1:0] rdq[$];
    logic [DW-1:0] wrq[$];

    // reference: current mode, remaining turnaround, pending command slot
    int            m_mode, m_left, m_to, m_starve;
    bit            m_valid, m_write;
    logic [DW-1:0] m_data;

    int n_chk, n_pass;
    int sc_rpop, sc_wpop, sc_rp_before_w, sc_turn, sc_busy, sc_acc_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_to = M_IDLE; m_starve = 0;
        m_valid = 1'b0; m_write = 1'b0; m_data = '0;
    endtask

    task automatic clr();
        sc_rpop = 0; sc_wpop = 0; sc_rp_before_w = 0; sc_turn = 0; sc_busy = 0; sc_acc_rd = 0;
    endtask

    task automatic step(input bit r, input bit fl, input bit rdy);
        bit rde, wre, ep_r, ep_w, hold, free;
        int nmode;
        @(negedge clk);
        rde = (rdq.size() == 0);
        wre = (wrq.size() == 0);
        rst = r; bus.wr_flush = fl; bus.cmd_ready = rdy;
        bus.rd_empty = rde; bus.wr_empty = wre;
        bus.rd_data = '0; bus.wr_data = '0;
        if (!rde) bus.rd_data = rdq[0];
        if (!wre) bus.wr_data = wrq[0];
        #1;
        chk("state", 32'(bus.state), 32'(m_mode));
        chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_valid));
        if (m_valid) begin
            chk("cmd_data", 32'(bus.cmd_data), 32'(m_data));
            chk("cmd_write", 32'(bus.cmd_write), 32'(m_write));
        end
        ep_r = 1'b0; ep_w = 1'b0;
        nmode = m_mode;
        hold = GUARD && (m_starve >= SL) && !wre;
        free = !m_valid || rdy;
        if (!r) begin
            case (m_mode)
                M_IDLE: begin
                    if (fl || (rde && !wre)) nmode = M_WRITE;
                    else if (!rde)           nmode = M_READ;
                end
                M_READ: begin
                    if (fl || (rde && !wre) || hold) begin
                        nmode = M_TURN; m_left = TC; m_to = M_WRITE;
                    end else if (rde && wre) nmode = M_IDLE;
                    else if (free)           ep_r = 1'b1;
                end
                M_WRITE: begin
                    if (!rde && (!fl || wre) && !hold) begin
                        nmode = M_TURN; m_left = TC; m_to = M_READ;
                    end else if (rde && wre) nmode = M_IDLE;
                    else if (free)           ep_w = 1'b1;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) nmode = m_to;
                end
            endcase
        end
        chk("rd_pop", 32'(bus.rd_pop), 32'(ep_r));
        chk("wr_pop", 32'(bus.wr_pop), 32'(ep_w));
        if (bus.rd_pop) sc_rpop++;
        if (bus.wr_pop) begin
            if (sc_wpop == 0) sc_rp_before_w = sc_rpop;
            sc_wpop++;
        end
        if (bus.state == 2'd3 && sc_wpop == 0) sc_turn++;
        if (bus.state != 2'd0 || bus.rd_pop || bus.wr_pop) sc_busy++;
        if (bus.cmd_valid && rdy && !bus.cmd_write) sc_acc_rd++;
        if (r) begin
            model_reset();
        end else begin
            m_mode = nmode;
            if (ep_r || ep_w) begin
                m_valid = 1'b1; m_write = ep_w;
                m_data = ep_w ? wrq[0] : rdq[0];
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (wre || ep_w) m_starve = 0;
            else if (ep_r)   m_starve++;
            if (ep_r) void'(rdq.pop_front());
            if (ep_w) void'(wrq.pop_front());
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        model_reset(); clr();
        rst = 1'b1;
        bus.wr_flush = 1'b0; bus.cmd_ready = 1'b0;
        bus.rd_empty = 1'b1; bus.wr_empty = 1'b1;
        bus.rd_data = '0; bus.wr_data = '0;
        repeat (2) @(posedge clk);

        // reset state
        step(1'b1, 1'b0, 1'b0);
        chk("rst_data", 32'(bus.cmd_data), 32'd0);
        chk("rst_write", 32'(bus.cmd_write), 32'd0);

        // both FIFOs empty: parked in IDLE
        clr();
        repeat (6) step(1'b0, 1'b0, 1'b1);
        chk("s6_busy", 32'(sc_busy), 32'd0);

        // three back-to-back reads
        clr();
        repeat (3) rdq.push_back(DW'($urandom));
        repeat (8) step(1'b0, 1'b0, 1'b1);
        chk("s1_rpops", 32'(sc_rpop), 32'd3);
        chk("s1_wpops", 32'(sc_wpop), 32'd0);
        chk("s1_rd_cmds", 32'(sc_acc_rd), 32'd3);

        // flush rises mid-READ with two writes queued
        clr();
        repeat (4) rdq.push_back(DW'($urandom));
        repeat (2) wrq.push_back(DW'($urandom));
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b1);
        chk("s2_turn_cycles", 32'(sc_turn), 32'(TC));
        chk("s2_wpops", 32'(sc_wpop), 32'd2);

        // downstream stall holds the pending command
        clr();
        rdq.push_back(8'hA1); rdq.push_back(8'hA2); rdq.push_back(8'hA3);
        repeat (2) step(1'b0, 1'b0, 1'b1);
        repeat (4) begin
            step(1'b0, 1'b0, 1'b0);
            chk("s3_valid", 32'(bus.cmd_valid), 32'd1);
            chk("s3_data", 32'(bus.cmd_data), 32'hA1);
        end
        chk("s3_rpops", 32'(sc_rpop), 32'd1);
        repeat (8) step(1'b0, 1'b0, 1'b1);

        // write starvation: 10 reads and 1 write, no flush
        clr();
        repeat (10) rdq.push_back(DW'($urandom));
        wrq.push_back(DW'($urandom));
        repeat (30) step(1'b0, 1'b0, 1'b1);
        chk("s4_wpops", 32'(sc_wpop), 32'd1);
        chk("s4_rd_before_wr", 32'(sc_rp_before_w), GUARD ? 32'(SL) : 32'd10);
        chk("s4_rpops", 32'(sc_rpop), 32'd10);

        // reset during TURN with a command pending
        clr();
        rdq.push_back(8'hB5); wrq.push_back(8'h5B);
        repeat (2) step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        chk("s5_pre_state", 32'(bus.state), 32'd3);
        chk("s5_pre_valid", 32'(bus.cmd_valid), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("s5_state", 32'(bus.state), 32'd0);
        chk("s5_valid", 32'(bus.cmd_valid), 32'd0);
        repeat (6) step(1'b0, 1'b0, 1'b1);

        // reset in READ with reads waiting: no pop under reset
        clr();
        repeat (2) rdq.push_back(DW'($urandom));
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("s5b_rpops", 32'(sc_rpop), 32'd0);
        repeat (6) step(1'b0, 1'b0, 1'b1);

        // random traffic
        repeat (400) begin
            if ($urandom_range(0, 2) == 0 && rdq.size() < 6) rdq.push_back(DW'($urandom));
            if ($urandom_range(0, 2) == 0 && wrq.size() < 6) wrq.push_back(DW'($urandom));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
